// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose: arbitrates NUM_REQ functional-unit results onto a single common
// data bus (CDB). It grants one requester per cycle and registers the granted
// tag and value into a one-cycle-latency broadcast.
//
// Optional feature macro: CDB_ARB_PRIO0_EN
//   undefined (default) : pure round-robin over all requesters.
//   defined             : requester 0 (load unit) always wins when valid.
//                         Requesters 1..NUM_REQ-1 share round-robin, and
//                         rr_ptr is not advanced on requester-0 grants.
//
// Ports:
//   clk          in   clock, rising-edge active
//   rst          in   synchronous reset, active low
//   stall_i      in   freezes all state and blocks grants (beats flush_i)
//   flush_i      in   squashes the in-flight broadcast and blocks grants
//   req_valid_i  in   [NUM_REQ]            per-requester result valid
//   req_tag_i    in   [NUM_REQ*TAG_WIDTH]  packed ROB tags
//   req_value_i  in   [NUM_REQ*VAL_WIDTH]  packed result values
//   req_ready_o  out  [NUM_REQ]            one-hot grant (combinational)
//   cdb_valid_o  out  registered broadcast valid
//   cdb_tag_o    out  registered broadcast tag
//   cdb_value_o  out  registered broadcast value
//   grant_id_o   out  index of the requester behind the current broadcast
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_WIDTH = 3,
    parameter int VAL_WIDTH = `XLEN,
    localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag_i,
    input  logic [NUM_REQ*VAL_WIDTH-1:0]   req_value_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic                           cdb_valid_o,
    output logic [TAG_WIDTH-1:0]           cdb_tag_o,
    output logic [VAL_WIDTH-1:0]           cdb_value_o,
    output logic [IDW-1:0]                 grant_id_o
);

    logic                 cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0] cdb_tag_q,   cdb_tag_d;
    logic [VAL_WIDTH-1:0] cdb_value_q, cdb_value_d;
    logic [IDW-1:0]       grant_id_q,  grant_id_d;
    logic [IDW-1:0]       rr_ptr_q,    rr_ptr_d;

    logic                 found_s;
    logic [IDW-1:0]       gnt_idx_s;
    logic [TAG_WIDTH-1:0] gnt_tag_s;
    logic [VAL_WIDTH-1:0] gnt_value_s;
    logic                 grant_en_s;

    // Select the winning requester: first valid at or after rr_ptr, wrapping.
    always_comb begin : search_blk
        int idx;
        found_s     = 1'b0;
        gnt_idx_s   = '0;
        gnt_tag_s   = '0;
        gnt_value_s = '0;
        idx         = 0;
`ifdef CDB_ARB_PRIO0_EN
        if (req_valid_i[0]) begin
            found_s     = 1'b1;
            gnt_idx_s   = '0;
            gnt_tag_s   = req_tag_i[0 +: TAG_WIDTH];
            gnt_value_s = req_value_i[0 +: VAL_WIDTH];
        end else begin
            // Requester 0 is excluded from the rotation; it is handled above.
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (!found_s && (idx != 0) && req_valid_i[idx]) begin
                    found_s     = 1'b1;
                    gnt_idx_s   = IDW'(idx);
                    gnt_tag_s   = req_tag_i[idx*TAG_WIDTH +: TAG_WIDTH];
                    gnt_value_s = req_value_i[idx*VAL_WIDTH +: VAL_WIDTH];
                end else begin
                    found_s = found_s;
                end
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found_s && req_valid_i[idx]) begin
                found_s     = 1'b1;
                gnt_idx_s   = IDW'(idx);
                gnt_tag_s   = req_tag_i[idx*TAG_WIDTH +: TAG_WIDTH];
                gnt_value_s = req_value_i[idx*VAL_WIDTH +: VAL_WIDTH];
            end else begin
                found_s = found_s;
            end
        end
`endif
    end

    // Grant is suppressed during reset, stall or flush; ready is one-hot.
    always_comb begin
        grant_en_s  = rst && !stall_i && !flush_i && found_s;
        req_ready_o = '0;
        if (grant_en_s) begin
            req_ready_o[gnt_idx_s] = 1'b1;
        end else begin
            req_ready_o = '0;
        end
    end

    // Next-state for broadcast registers and round-robin pointer.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (stall_i) begin
            cdb_valid_d = cdb_valid_q;
        end else if (flush_i) begin
            cdb_valid_d = 1'b0;
        end else if (grant_en_s) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = gnt_tag_s;
            cdb_value_d = gnt_value_s;
            grant_id_d  = gnt_idx_s;
`ifdef CDB_ARB_PRIO0_EN
            if (gnt_idx_s != '0) begin
                rr_ptr_d = (gnt_idx_s == IDW'(NUM_REQ-1)) ? '0 : gnt_idx_s + IDW'(1);
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
`else
            rr_ptr_d = (gnt_idx_s == IDW'(NUM_REQ-1)) ? '0 : gnt_idx_s + IDW'(1);
`endif
        end else begin
            cdb_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset (reset beats stall/flush).
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_value_o = cdb_value_q;
    assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_REQ=4,
// TAG_WIDTH=3, VAL_WIDTH=32). Inputs change 1 ns after the rising edge, the
// combinational grant is sampled 1 ns later, registered outputs are sampled
// 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  req_valid_i = 4'b0000;
    logic [11:0] req_tag_i = 12'd0;
    logic [127:0] req_value_i = 128'd0;
    logic [3:0]  req_ready_o;
    logic        cdb_valid_o;
    logic [2:0]  cdb_tag_o;
    logic [31:0] cdb_value_o;
    logic [1:0]  grant_id_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cdb_arbiter #(.NUM_REQ(4), .TAG_WIDTH(3), .VAL_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_tag_i(req_tag_i),
        .req_value_i(req_value_i), .req_ready_o(req_ready_o),
        .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o),
        .cdb_value_o(cdb_value_o), .grant_id_o(grant_id_o)
    );

    always #5 clk = ~clk;

    // Requester i carries tag 4+i and value A000_000i.
    function automatic logic [2:0] exp_tag(input int i);
        return 3'(4 + i);
    endfunction

    function automatic logic [31:0] exp_val(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic load_default_data();
        req_tag_i   = {3'd7, 3'd6, 3'd5, 3'd4};
        req_value_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        load_default_data();
        req_valid_i = 4'b1111;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0000) $display("FAIL reset_ready: got %b want %b", req_ready_o, 4'b0000);
        else pass_cnt++;
        next_cycle();
        next_cycle();
        total_cnt++;
        if ({cdb_valid_o, cdb_tag_o, cdb_value_o, grant_id_o} !== 38'd0)
            $display("FAIL reset_state: got v=%b t=%0d val=%h id=%0d want all zero",
                     cdb_valid_o, cdb_tag_o, cdb_value_o, grant_id_o);
        else pass_cnt++;
        req_valid_i = 4'b0000;
        rst = 1'b1;
    endtask

    task automatic test_single();
        req_tag_i   = {3'd7, 3'd6, 3'd5, 3'd5};
        req_value_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hDEAD_BEEF};
        req_valid_i = 4'b0001;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0001) $display("FAIL single_ready: got %b want %b", req_ready_o, 4'b0001);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (cdb_valid_o !== 1'b1 || cdb_tag_o !== 3'd5 || cdb_value_o !== 32'hDEAD_BEEF || grant_id_o !== 2'd0)
            $display("FAIL single_bcast: got v=%b t=%0d val=%h id=%0d want v=1 t=5 val=deadbeef id=0",
                     cdb_valid_o, cdb_tag_o, cdb_value_o, grant_id_o);
        else pass_cnt++;
        req_valid_i = 4'b0000;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0000) $display("FAIL idle_ready: got %b want %b", req_ready_o, 4'b0000);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (cdb_valid_o !== 1'b0 || cdb_tag_o !== 3'd5 || cdb_value_o !== 32'hDEAD_BEEF || grant_id_o !== 2'd0)
            $display("FAIL idle_clear: got v=%b t=%0d val=%h id=%0d want v=0 t=5 val=deadbeef id=0",
                     cdb_valid_o, cdb_tag_o, cdb_value_o, grant_id_o);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        // Fresh reset so the rotation starts at rr_ptr=0.
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        load_default_data();
        req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            total_cnt++;
            if (req_ready_o !== 4'(1 << (k % 4)))
                $display("FAIL rot_ready[%0d]: got %b want %b", k, req_ready_o, 4'(1 << (k % 4)));
            else pass_cnt++;
            next_cycle();
            total_cnt++;
            if (cdb_valid_o !== 1'b1 || grant_id_o !== 2'(k % 4) || cdb_tag_o !== exp_tag(k % 4) ||
                cdb_value_o !== exp_val(k % 4))
                $display("FAIL rot_bcast[%0d]: got v=%b id=%0d t=%0d val=%h want v=1 id=%0d t=%0d val=%h",
                         k, cdb_valid_o, grant_id_o, cdb_tag_o, cdb_value_o,
                         k % 4, exp_tag(k % 4), exp_val(k % 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        // rr_ptr is 0; grant requester 2 alone to move it to 3.
        req_valid_i = 4'b0100;
        next_cycle();
        req_valid_i = 4'b1001;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b1000) $display("FAIL wrap_first: got %b want %b", req_ready_o, 4'b1000);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (grant_id_o !== 2'd3 || cdb_tag_o !== 3'd7) $display("FAIL wrap_id3: got id=%0d t=%0d want id=3 t=7", grant_id_o, cdb_tag_o);
        else pass_cnt++;
        req_valid_i = 4'b0001;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0001) $display("FAIL wrap_second: got %b want %b", req_ready_o, 4'b0001);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (grant_id_o !== 2'd0 || cdb_valid_o !== 1'b1) $display("FAIL wrap_id0: got id=%0d v=%b want id=0 v=1", grant_id_o, cdb_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        // rr_ptr=1: grant requester 1 (rr_ptr -> 2), then stall for 3 cycles.
        req_valid_i = 4'b1111;
        next_cycle();
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            flush_i = (k == 1);
            #1;
            total_cnt++;
            if (req_ready_o !== 4'b0000) $display("FAIL stall_ready[%0d]: got %b want %b", k, req_ready_o, 4'b0000);
            else pass_cnt++;
            next_cycle();
            total_cnt++;
            if (cdb_valid_o !== 1'b1 || grant_id_o !== 2'd1 || cdb_tag_o !== 3'd5 || cdb_value_o !== 32'hA000_0001)
                $display("FAIL stall_hold[%0d]: got v=%b id=%0d t=%0d val=%h want v=1 id=1 t=5 val=a0000001",
                         k, cdb_valid_o, grant_id_o, cdb_tag_o, cdb_value_o);
            else pass_cnt++;
        end
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0100) $display("FAIL stall_resume: got %b want %b", req_ready_o, 4'b0100);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (grant_id_o !== 2'd2) $display("FAIL stall_resume_id: got %0d want 2", grant_id_o);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        // cdb_valid_o=1 from grant 2, rr_ptr=3.
        flush_i = 1'b1;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0000) $display("FAIL flush_ready: got %b want %b", req_ready_o, 4'b0000);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (cdb_valid_o !== 1'b0 || grant_id_o !== 2'd2 || cdb_tag_o !== 3'd6)
            $display("FAIL flush_clear: got v=%b id=%0d t=%0d want v=0 id=2 t=6", cdb_valid_o, grant_id_o, cdb_tag_o);
        else pass_cnt++;
        flush_i = 1'b0;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b1000) $display("FAIL flush_ptr: got %b want %b", req_ready_o, 4'b1000);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        // rr_ptr=0 after grant 3; grant 0 so rr_ptr=1 and a broadcast is live.
        req_valid_i = 4'b1111;
        next_cycle();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0000) $display("FAIL rstmid_ready: got %b want %b", req_ready_o, 4'b0000);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (cdb_valid_o !== 1'b0 || cdb_tag_o !== 3'd0 || cdb_value_o !== 32'd0 || grant_id_o !== 2'd0)
            $display("FAIL rstmid_drop: got v=%b t=%0d val=%h id=%0d want all zero",
                     cdb_valid_o, cdb_tag_o, cdb_value_o, grant_id_o);
        else pass_cnt++;
        rst = 1'b1;
        req_valid_i = 4'b0000;
        next_cycle();
        total_cnt++;
        if (cdb_valid_o !== 1'b0) $display("FAIL rstmid_noreplay: got %b want 0", cdb_valid_o);
        else pass_cnt++;
        req_valid_i = 4'b1111;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0001) $display("FAIL rstmid_ptr: got %b want %b", req_ready_o, 4'b0001);
        else pass_cnt++;
        next_cycle();
        req_valid_i = 4'b0000;
    endtask

    task automatic test_prio0();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        load_default_data();
        req_valid_i = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++;
            if (req_ready_o !== 4'b0001) $display("FAIL prio_ready[%0d]: got %b want %b", k, req_ready_o, 4'b0001);
            else pass_cnt++;
            next_cycle();
            total_cnt++;
            if (grant_id_o !== 2'd0 || cdb_valid_o !== 1'b1) $display("FAIL prio_id[%0d]: got id=%0d v=%b want id=0 v=1", k, grant_id_o, cdb_valid_o);
            else pass_cnt++;
        end
        req_valid_i = 4'b0110;
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0010) $display("FAIL prio_rr1: got %b want %b", req_ready_o, 4'b0010);
        else pass_cnt++;
        next_cycle();
        #1;
        total_cnt++;
        if (req_ready_o !== 4'b0100) $display("FAIL prio_rr2: got %b want %b", req_ready_o, 4'b0100);
        else pass_cnt++;
        next_cycle();
        total_cnt++;
        if (grant_id_o !== 2'd2) $display("FAIL prio_rr2_id: got %0d want 2", grant_id_o);
        else pass_cnt++;
        req_valid_i = 4'b0000;
    endtask

    initial begin
        test_reset();
`ifdef CDB_ARB_PRIO0_EN
        test_prio0();
`else
        test_single();
        test_rotation();
        test_wrap();
        test_stall();
        test_flush();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of functional-unit requesters sharing the CDB.
REQ-002 SHALL have parameter TAG_WIDTH, default 3: ROB tag width, equal to the reorder buffer ADDR_WIDTH.
REQ-003 SHALL have parameter VAL_WIDTH, default `XLEN: result value width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-low reset.
REQ-006 SHALL have port stall_i  input  1: pipeline stall; freezes all state.
REQ-007 SHALL have port flush_i  input  1: squash; discards the in-flight broadcast.
REQ-008 SHALL have port req_valid_i  input  NUM_REQ: per-requester result valid.
REQ-009 SHALL have port req_tag_i  input  NUM_REQ*TAG_WIDTH: per-requester ROB tag; requester i occupies slice [i*TAG_WIDTH +: TAG_WIDTH].
REQ-010 SHALL have port req_value_i  input  NUM_REQ*VAL_WIDTH: per-requester result, packed in the same way as req_tag_i.
REQ-011 SHALL have port req_ready_o  output  NUM_REQ: one-hot grant; the result is accepted this cycle.
REQ-012 SHALL have port cdb_valid_o  output  1: registered broadcast valid; drives the ROB cdb_valid.
REQ-013 SHALL have port cdb_tag_o  output  TAG_WIDTH: registered broadcast tag.
REQ-014 SHALL have port cdb_value_o  output  VAL_WIDTH: registered broadcast value.
REQ-015 SHALL have port grant_id_o  output  $clog2(NUM_REQ): index of the requester that sourced the current broadcast.

Function
REQ-016 SHALL transfer a result only in a cycle where req_valid_i[i] and req_ready_o[i] are both high.
REQ-017 SHALL assert at most one bit of req_ready_o per cycle, combinationally from req_valid_i and the round-robin pointer.
REQ-018 SHALL drive req_ready_o to all-zero while stall_i, flush_i or rst is asserted (rst low).
REQ-019 SHALL select the first valid requester at or after pointer rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-020 SHALL load rr_ptr with (granted index + 1) mod NUM_REQ on every grant, and hold it otherwise.
REQ-021 SHALL register the granted tag and value into cdb_tag_o and cdb_value_o, set cdb_valid_o, and set grant_id_o, giving 1-cycle latency from acceptance to broadcast.
REQ-022 SHALL clear cdb_valid_o at the next edge after a non-stalled cycle with no grant; cdb_tag_o, cdb_value_o and grant_id_o hold their values.
REQ-023 SHALL hold cdb_valid_o, cdb_tag_o, cdb_value_o, grant_id_o and rr_ptr unchanged while stall_i is high; stall_i takes precedence over flush_i.
REQ-024 SHALL, on flush_i without stall_i, clear cdb_valid_o at the next edge, hold rr_ptr, and make no grant.
REQ-025 SHALL leave requesters that are not granted untouched; each such requester holds valid, tag and value stable until its acceptance cycle.
REQ-026 SHALL hold all state when req_valid_i is all-zero, except for the cdb_valid_o clear in REQ-022.

Reset
REQ-027 SHALL, on rst low at a rising clk edge, set cdb_valid_o=0, cdb_tag_o=0, cdb_value_o=0, grant_id_o=0 and rr_ptr=0.
REQ-028 SHALL give rst priority over stall_i and flush_i.
REQ-029 SHALL, when reset lands mid-broadcast, drop the registered broadcast without replay.

Configuration
REQ-030 SHALL, with CDB_ARB_PRIO0_EN defined, grant requester 0 whenever req_valid_i[0] is high (the load unit has fixed top priority).
REQ-031 SHALL, with CDB_ARB_PRIO0_EN defined, arbitrate requesters 1..NUM_REQ-1 round-robin, and SHALL NOT update rr_ptr on requester-0 grants.
REQ-032 SHALL, with CDB_ARB_PRIO0_EN undefined, apply pure round-robin over all NUM_REQ requesters as in REQ-019 and REQ-020.

Verification
REQ-033 Scenario: after reset, req_valid_i=4'b0001, tag 3'd5, value 32'hDEAD_BEEF -> req_ready_o=4'b0001 the same cycle; next cycle cdb_valid_o=1, cdb_tag_o=5, cdb_value_o=32'hDEAD_BEEF, grant_id_o=0.
REQ-034 Scenario: req_valid_i=4'b1111 held for 8 cycles (macro undefined) -> grant order 0,1,2,3,0,1,2,3, with one cdb_valid_o pulse per cycle.
REQ-035 Scenario: rr_ptr=3, req_valid_i=4'b1001 -> grant 3 first, then 0 (wrap-around).
REQ-036 Scenario: stall_i high for 3 cycles with requests pending -> req_ready_o=0, outputs frozen; on release, grant resumes at the unchanged rr_ptr.
REQ-037 Scenario: flush_i pulsed while cdb_valid_o=1 -> cdb_valid_o=0 next cycle, no grant that cycle, rr_ptr unchanged.
REQ-038 Scenario: CDB_ARB_PRIO0_EN defined, req_valid_i=4'b0111 held 4 cycles -> requester 0 granted every cycle, requesters 1 and 2 starved; drop req0 -> 1 then 2 granted.
